// File: rtl/i_ref_pkg.sv
// i_ref_pkg: shared state encoding, mode constants and circular-pointer helper for i_ref_history.
package i_ref_pkg;
    typedef enum logic [1:0] {TRACK, SCAN, DONE, HOLD} state_t;
    localparam logic MODE_TAP = 1'b0;
    localparam logic MODE_MAX = 1'b1;
    function automatic int wrap_dec(input int ptr, input int dec, input int depth);
        return (ptr >= dec) ? ptr - dec : ptr - dec + depth;
    endfunction
endpackage

// File: rtl/i_ref_hist_buf.sv
// i_ref_hist_buf: DEPTH x BUS_WIDTH history storage, one write port, combinational read, no reset.
module i_ref_hist_buf #(
    parameter int BUS_WIDTH = 10,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [AW-1:0]        wa,
    input  logic [BUS_WIDTH-1:0] d,
    input  logic [AW-1:0]        ra,
    output logic [BUS_WIDTH-1:0] q
);
    logic [BUS_WIDTH-1:0] mem [DEPTH];
    always_ff @(posedge clk)
        if (we) mem[wa] <= d;
    assign q = mem[ra];
endmodule

// File: rtl/i_ref_history.sv
// i_ref_history: circular i_ref sample history; on a went_unstable rising edge it freezes and
// scans back to return either the sample lag strobes ago (TAP) or the max of the newest lag+1 (MAX).
module i_ref_history
    import i_ref_pkg::*;
#(
    parameter int BUS_WIDTH = 10,
    parameter int DEPTH = 8,
    localparam int LAG_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BUS_WIDTH-1:0] i_ref,
    input  logic                 enable,
    input  logic                 ready,
    input  logic                 went_unstable,
    input  logic                 clear,
    input  logic [LAG_W-1:0]     lag,
    input  logic                 mode,
    output logic [BUS_WIDTH-1:0] i_ref_max,
    output logic                 max_valid,
    output logic                 done,
    output logic                 busy,
    output logic [CNT_W-1:0]     fill_count
);
    localparam logic [BUS_WIDTH-1:0] ALL_ONES = '1;

    state_t               state, state_nx;
    logic                 went_q, trig, we, last, mode_q;
    logic [LAG_W-1:0]     wr_ptr, rd_ptr, k, eff_lag, lag_c, fill_m1;
    logic [BUS_WIDTH-1:0] acc, acc_nx, entry;

    assign trig    = enable & went_unstable & ~went_q;
    assign we      = (state == TRACK) & enable & ready & ~went_unstable & ~clear;
    assign rd_ptr  = LAG_W'(wrap_dec(int'(wr_ptr), int'(k) + 1, DEPTH));
    assign lag_c   = (int'(lag) > DEPTH - 1) ? LAG_W'(DEPTH - 1) : lag;
    assign fill_m1 = LAG_W'(fill_count - CNT_W'(1));
    assign last    = k == eff_lag;
    // k == 0 seeds the accumulator so stale acc from a previous scan never leaks in
    assign acc_nx  = (mode_q == MODE_MAX && k != '0 && acc > entry) ? acc : entry;
    assign busy    = state == SCAN;
    assign done    = state == DONE;

    i_ref_hist_buf #(.BUS_WIDTH(BUS_WIDTH), .DEPTH(DEPTH)) u_buf (
        .clk(clk),
        .we (we),
        .wa (wr_ptr),
        .d  (i_ref),
        .ra (rd_ptr),
        .q  (entry)
    );

    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= TRACK;
        else      state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            TRACK:   state_nx = (trig && !clear) ? ((fill_count == '0) ? DONE : SCAN) : TRACK;
            SCAN:    state_nx = clear ? TRACK : (last ? DONE : SCAN);
            DONE:    state_nx = HOLD;
            HOLD:    state_nx = went_unstable ? HOLD : TRACK;
            default: state_nx = TRACK;
        endcase
    end

    // i_ref_max is loaded on entry to DONE so it is already valid while done is high
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            went_q     <= 1'b0;
            wr_ptr     <= '0;
            fill_count <= '0;
            max_valid  <= 1'b0;
            i_ref_max  <= ALL_ONES;
            mode_q     <= MODE_TAP;
            eff_lag    <= '0;
            k          <= '0;
            acc        <= '0;
        end else begin
            went_q <= went_unstable;
            if (clear) begin
                wr_ptr     <= '0;
                fill_count <= '0;
                max_valid  <= 1'b0;
            end else if (we) begin
                wr_ptr <= (wr_ptr == LAG_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
                if (fill_count != CNT_W'(DEPTH)) fill_count <= fill_count + 1'b1;
            end
            if (state == TRACK && trig && !clear) begin
                mode_q  <= mode;
                eff_lag <= (lag_c < fill_m1) ? lag_c : fill_m1;
                k       <= '0;
                if (fill_count == '0) i_ref_max <= ALL_ONES;
            end
            if (state == SCAN && !clear) begin
                acc <= acc_nx;
                k   <= k + 1'b1;
                if (last) begin
                    i_ref_max <= acc_nx;
                    max_valid <= 1'b1;
                end
            end
        end
endmodule

// File: tb/tb_i_ref_history.sv
// tb_i_ref_history: table-driven capture vectors checked through a done-pulse scoreboard,
// plus hand sequences for event/write collisions, held triggers, clear, enable and async reset.
module tb_i_ref_history;
    logic       clk, rst, enable, ready, went_unstable, clear, mode, max_valid, done, busy;
    logic [9:0] i_ref, i_ref_max;
    logic [1:0] lag;
    logic [2:0] fill_count;

    int total = 0, bad = 0, cyc = 0, busy_cnt = 0, done_cnt = 0, d0;

    typedef struct { int val; bit mv; int c0; int lat; } exp_t;
    exp_t sb[$];
    exp_t r;

    typedef struct { bit clr; int n; int w[6]; bit m; int lg; int val; bit mv; int lat; int fill; } vec_t;
    vec_t vt[7];

    i_ref_history #(.BUS_WIDTH(10), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .i_ref(i_ref), .enable(enable), .ready(ready),
        .went_unstable(went_unstable), .clear(clear), .lag(lag), .mode(mode),
        .i_ref_max(i_ref_max), .max_valid(max_valid), .done(done), .busy(busy),
        .fill_count(fill_count)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (busy) busy_cnt++;
        if (done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 expected done=0 (i_ref_max=%0d)", i_ref_max);
            end else begin
                r = sb.pop_front();
                chk("i_ref_max", int'(i_ref_max), r.val);
                chk("max_valid", int'(max_valid), int'(r.mv));
                chk("latency", cyc - r.c0, r.lat);
                chk("busy_cycles", busy_cnt, r.lat - 1);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int v);
        ready = 1;
        i_ref = 10'(v);
        step();
        ready = 0;
    endtask

    task automatic cap(input bit m, input int lg, input int v, input bit mv, input int lat,
                       input int hold, input bit rdy);
        sb.push_back('{v, mv, cyc, lat});
        busy_cnt = 0;
        mode = m;
        lag = 2'(lg);
        went_unstable = 1;
        ready = rdy;
        i_ref = 10'd777;
        repeat (hold) step();
        went_unstable = 0;
        ready = 0;
        for (int i = 0; i < 20 && sb.size() != 0; i++) step();
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL capture_timeout: got no done expected done within bound");
            sb.delete();
        end
        repeat (2) step();
    endtask

    initial begin
        vt[0] = '{1'b1, 5, '{10, 20, 30, 40, 50, 0}, 1'b0, 3, 20,   1'b1, 5, 4};
        vt[1] = '{1'b1, 4, '{5, 90, 7, 3, 0, 0},     1'b1, 3, 90,   1'b1, 5, 4};
        vt[2] = '{1'b0, 0, '{0, 0, 0, 0, 0, 0},      1'b1, 1, 7,    1'b1, 3, 4};
        vt[3] = '{1'b1, 2, '{100, 200, 0, 0, 0, 0},  1'b0, 3, 100,  1'b1, 3, 2};
        vt[4] = '{1'b1, 0, '{0, 0, 0, 0, 0, 0},      1'b0, 2, 1023, 1'b0, 1, 0};
        vt[5] = '{1'b1, 6, '{1, 2, 3, 4, 5, 6},      1'b1, 3, 6,    1'b1, 5, 4};
        vt[6] = '{1'b0, 0, '{0, 0, 0, 0, 0, 0},      1'b0, 0, 6,    1'b1, 2, 4};

        rst = 0; enable = 1; ready = 0; went_unstable = 0; clear = 0; mode = 0; lag = 0; i_ref = 0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_i_ref_max", int'(i_ref_max), 1023);
        chk("rst_max_valid", int'(max_valid), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_fill", int'(fill_count), 0);
        rst = 1;
        step();

        foreach (vt[v]) begin
            if (vt[v].clr) begin
                clear = 1;
                step();
                clear = 0;
            end
            for (int j = 0; j < vt[v].n; j++) wr(vt[v].w[j]);
            cap(vt[v].m, vt[v].lg, vt[v].val, vt[v].mv, vt[v].lat, 1, 1'b0);
            chk($sformatf("vec%0d_fill", v), int'(fill_count), vt[v].fill);
        end

        // ready together with the event: the new sample must not land in the history
        cap(1'b0, 0, 6, 1'b1, 2, 1, 1'b1);
        chk("collide_fill", int'(fill_count), 4);

        d0 = done_cnt;
        cap(1'b0, 0, 6, 1'b1, 2, 20, 1'b0);
        chk("held_one_done", done_cnt - d0, 1);

        d0 = done_cnt;
        mode = 1;
        lag = 3;
        went_unstable = 1;
        step();
        went_unstable = 0;
        step();
        clear = 1;
        step();
        clear = 0;
        @(negedge clk);
        chk("clr_busy", int'(busy), 0);
        chk("clr_fill", int'(fill_count), 0);
        chk("clr_max_valid", int'(max_valid), 0);
        chk("clr_i_ref_max", int'(i_ref_max), 6);
        repeat (8) step();
        chk("clr_no_done", done_cnt - d0, 0);

        d0 = done_cnt;
        busy_cnt = 0;
        enable = 0;
        for (int i = 0; i < 6; i++) begin
            ready = i[0];
            i_ref = 10'(i * 11 + 1);
            went_unstable = (i == 2);
            step();
        end
        ready = 0;
        went_unstable = 0;
        repeat (3) step();
        chk("dis_fill", int'(fill_count), 0);
        chk("dis_busy", busy_cnt, 0);
        chk("dis_done", done_cnt - d0, 0);
        chk("dis_i_ref_max", int'(i_ref_max), 6);
        chk("dis_max_valid", int'(max_valid), 0);
        enable = 1;
        step();

        wr(11); wr(22); wr(33); wr(44);
        mode = 1;
        lag = 3;
        went_unstable = 1;
        step();
        went_unstable = 0;
        step();
        chk("pre_rst_busy", int'(busy), 1);
        #2 rst = 0;
        #1;
        chk("arst_busy", int'(busy), 0);
        chk("arst_i_ref_max", int'(i_ref_max), 1023);
        chk("arst_fill", int'(fill_count), 0);
        step();
        rst = 1;
        repeat (2) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/i_ref_history.md
Name: i_ref_history

Overview:
Parametrised successor of the fixed four-stage reference-current sampler. Keeps a DEPTH-deep circular history of i_ref samples taken on each ready strobe. On a rising edge of went_unstable it freezes the history and performs a sequential scan. The scan returns either the sample a programmable number of strobes back (TAP mode) or the maximum over the most recent window (MAX mode). Sits between the ADC/reference front end and the stability controller, which reloads i_ref_max as the safe operating reference.

Parameters:
BUS_WIDTH, 10, width of i_ref samples and of i_ref_max
DEPTH, 8, history entries; any integer >= 2, not required to be a power of two
LAG_W, $clog2(DEPTH), localparam, width of lag
CNT_W, $clog2(DEPTH+1), localparam, width of fill_count

Ports:
clk  input  1  single system clock, rising edge
rst  input  1  reset, asynchronous assert, active-low
i_ref  input  BUS_WIDTH  reference current sample
enable  input  1  block enable; low blocks sampling and new events
ready  input  1  sample strobe; one write per cycle high
went_unstable  input  1  instability flag; a rising edge triggers a capture
clear  input  1  synchronous history flush
lag  input  LAG_W  scan lag, sampled on the trigger cycle
mode  input  1  0 = TAP (sample at lag), 1 = MAX (max over lag+1 newest)
i_ref_max  output  BUS_WIDTH  captured reference
max_valid  output  1  sticky; set on first completed scan with fill_count > 0
done  output  1  one-cycle pulse when i_ref_max updates
busy  output  1  high while in SCAN
fill_count  output  CNT_W  valid entries, saturating at DEPTH

Behaviour:
- Reset (rst low, asynchronous):
  - i_ref_max = 2**BUS_WIDTH-1; max_valid, done, busy = 0.
  - fill_count = 0, wr_ptr = 0, state = TRACK, went_unstable edge register = 0.
  - Buffer contents are don't-care.
- Trigger: trig = enable & went_unstable & !went_unstable_q, where went_unstable_q is the registered previous value.
- States:
  - TRACK:
    - enable & ready & !went_unstable & !clear: buf[wr_ptr] <= i_ref; wr_ptr wraps DEPTH-1 -> 0; fill_count increments, saturating at DEPTH.
    - On trig: latch mode; latch eff_lag = min(lag, fill_count-1), with lag values >= DEPTH clamped to DEPTH-1; k = 0.
    - If fill_count == 0, go DONE directly and skip SCAN; otherwise go SCAN.
  - SCAN (busy = 1):
    - Each cycle read buf[(wr_ptr-1-k) mod DEPTH].
    - MAX mode: acc = max(acc, entry), unsigned compare, acc seeded by the k=0 entry.
    - TAP mode: acc = entry.
    - k increments each cycle. After k = eff_lag is processed, go DONE.
    - Scan length is eff_lag+1 cycles.
  - DONE (one cycle):
    - i_ref_max <= acc, or 2**BUS_WIDTH-1 if fill_count was 0.
    - done = 1. max_valid <= 1 if fill_count > 0.
    - Go HOLD.
  - HOLD: no writes. Go TRACK in the first cycle with went_unstable low.
- Latency: trigger cycle to done pulse = eff_lag+2 cycles; with an empty buffer, 1 cycle.
- Simultaneous events and boundaries:
  - ready with went_unstable high: no write; the event has priority.
  - trig during SCAN, DONE or HOLD: ignored. Level-held went_unstable yields exactly one capture.
  - clear: wr_ptr = 0, fill_count = 0, max_valid = 0; i_ref_max unchanged.
  - clear in SCAN: aborts the scan; go TRACK, no done pulse.
  - clear in the same cycle as trig: clear wins, trig dropped.
  - enable low mid-SCAN: the scan completes; enable gates only writes and new triggers.
  - lag and mode changes after the trigger cycle have no effect on the scan in progress.
  - Wrap-around: after more than DEPTH writes, the oldest entry is overwritten. fill_count stays at DEPTH.

Decomposition:
- Package i_ref_pkg:
  - State enum: TRACK, SCAN, DONE, HOLD.
  - Mode constants: MODE_TAP = 0, MODE_MAX = 1.
  - Function for the wrapped pointer decrement.
- One sub-module, i_ref_hist_buf: DEPTH x BUS_WIDTH register file, one write port and one combinational read port, no reset on storage.
- FSM, pointers, accumulator and output registers stay in the top module.

Test Plan:
- Reset, with DEPTH=4, BUS_WIDTH=10 (same in all scenarios) -> i_ref_max=1023, max_valid=0, done=0, fill_count=0. Drive rst low mid-SCAN -> busy=0 and i_ref_max=1023 immediately, without waiting for a clock edge.
- TAP, legacy equivalence: write 10,20,30,40,50; trigger with mode=0, lag=3 -> busy for 4 cycles, then done with i_ref_max=20, max_valid=1, fill_count=4.
- MAX: write 5,90,7,3; trigger mode=1, lag=3 -> 90. Re-arm (went_unstable low), trigger with lag=1 -> 7, done 3 cycles after the trigger.
- Partial fill and empty:
  - After clear, write 100,200; trigger TAP, lag=3 -> eff_lag=1, i_ref_max=100.
  - After clear, trigger with no writes -> done 1 cycle later, i_ref_max=1023, max_valid=0.
- Simultaneity:
  - ready and went_unstable high together -> no write, fill_count unchanged.
  - went_unstable held high for 20 cycles -> exactly one done pulse.
  - clear asserted during SCAN -> no done pulse, fill_count=0, i_ref_max keeps its old value.
- enable=0 with ready toggling and a went_unstable rising edge -> no writes, no scan, all outputs stable.
